// File: rtl/counter_gray_rx_delta_pkg.sv
// Shared types and defaults for the Gray-count receive path.
package counter_gray_rx_delta_pkg;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_PRIME = 2'd1,
        S_RUN   = 2'd2
    } state_e;

    localparam int unsigned GRAY_W = 4;

endpackage

// File: rtl/counter_gray_rx_delta_gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all Gray bits at or above it.
module counter_gray2bin #(
    parameter int unsigned W = counter_gray_rx_delta_pkg::GRAY_W
) (
    input  logic [W-1:0] gray_i,
    output logic [W-1:0] bin_o
);

    always_comb begin
        bin_o = '0;
        for (int unsigned i = 0; i < W; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/counter_gray_rx_delta.sv
// Destination-domain consumer of a synchronised Gray count: binary value, per-cycle delta,
// saturating event accumulator and sticky illegal-transition flag.
module counter_gray_rx_delta
    import counter_gray_rx_delta_pkg::*;
#(
    parameter int unsigned BUS_WIDTH = GRAY_W,
    parameter int unsigned ACC_WIDTH = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic [BUS_WIDTH-1:0] i_gray,
    input  logic                 i_resync,
    input  logic                 i_clr,
    input  logic                 i_err_clr,
    output logic [BUS_WIDTH-1:0] o_bin,
    output logic [BUS_WIDTH-1:0] o_delta,
    output logic                 o_delta_vld,
    output logic [ACC_WIDTH-1:0] o_acc,
    output logic                 o_acc_ovf,
    output logic                 o_err,
    output logic                 o_primed
);

    function automatic int unsigned popcount(input logic [BUS_WIDTH-1:0] v);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < BUS_WIDTH; i++) begin
            cnt = cnt + int'(v[i]);
        end
        return cnt;
    endfunction

    state_e               state_q;
    logic [BUS_WIDTH-1:0] g_q, g_prev_q, bin_prev_q, bin_q, delta_q;
    logic                 vld_q, ovf_q, err_q;
    logic [ACC_WIDTH-1:0] acc_q;

    logic [BUS_WIDTH-1:0] bin_now, delta_now;
    int unsigned          ham;
    logic                 run_active, accept, illegal;
    logic [ACC_WIDTH-1:0] acc_base;
    logic [ACC_WIDTH:0]   acc_sum;
    logic [ACC_WIDTH-1:0] acc_d;
    logic                 ovf_d, err_d;

    counter_gray2bin #(.W(BUS_WIDTH)) u_g2b (
        .gray_i (g_q),
        .bin_o  (bin_now)
    );

    always_comb begin
        delta_now  = bin_now - bin_prev_q;
        ham        = popcount(g_q ^ g_prev_q);
        run_active = (state_q == S_RUN) && !i_resync;
        accept     = run_active && (ham == 1);
        illegal    = run_active && (ham > 1);
        // Clear is applied before the same-cycle delta is added, so no event is dropped.
        acc_base   = i_clr ? '0 : acc_q;
        acc_sum    = {1'b0, acc_base} + {{(ACC_WIDTH + 1 - BUS_WIDTH){1'b0}}, delta_now};
        acc_d      = acc_base;
        if (accept) begin
            acc_d = acc_sum[ACC_WIDTH] ? '1 : acc_sum[ACC_WIDTH-1:0];
        end
        ovf_d = (ovf_q && !i_clr) || (accept && acc_sum[ACC_WIDTH]);
        err_d = illegal || (err_q && !i_err_clr);
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= S_WAIT;
            g_q        <= '0;
            g_prev_q   <= '0;
            bin_prev_q <= '0;
            bin_q      <= '0;
            delta_q    <= '0;
            vld_q      <= 1'b0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            g_q   <= i_gray;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            unique case (state_q)
                S_WAIT: begin
                    state_q <= S_PRIME;
                    delta_q <= '0;
                    vld_q   <= 1'b0;
                end
                S_PRIME: begin
                    g_prev_q   <= g_q;
                    bin_prev_q <= bin_now;
                    bin_q      <= bin_now;
                    delta_q    <= '0;
                    vld_q      <= 1'b0;
                    state_q    <= i_resync ? S_PRIME : S_RUN;
                end
                S_RUN: begin
                    if (i_resync) begin
                        state_q <= S_PRIME;
                        delta_q <= '0;
                        vld_q   <= 1'b0;
                    end else begin
                        // Every sample is adopted as the new reference, even an illegal one.
                        g_prev_q   <= g_q;
                        bin_prev_q <= bin_now;
                        bin_q      <= bin_now;
                        delta_q    <= accept ? delta_now : '0;
                        vld_q      <= accept;
                    end
                end
                default: begin
                    state_q <= S_WAIT;
                    delta_q <= '0;
                    vld_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_bin       = bin_q;
    assign o_delta     = delta_q;
    assign o_delta_vld = vld_q;
    assign o_acc       = acc_q;
    assign o_acc_ovf   = ovf_q;
    assign o_err       = err_q;
    assign o_primed    = (state_q == S_RUN);

endmodule

// File: tb/tb_counter_gray_rx_delta.sv
// Self-checking bench: directed scenarios plus a random Gray walk against a behavioural model,
// driving a 16-bit and a 4-bit accumulator instance from the same inputs.
module tb_counter_gray_rx_delta;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] gray = '0;
    logic         resync = 1'b0, clr = 1'b0, err_clr = 1'b0;

    logic [W-1:0] bin_a, delta_a, bin_b, delta_b;
    logic         vld_a, ovf_a, err_a, primed_a, vld_b, ovf_b, err_b, primed_b;
    logic [15:0]  acc_a;
    logic [3:0]   acc_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    counter_gray_rx_delta #(.BUS_WIDTH(W), .ACC_WIDTH(16)) dut_a (
        .i_clk(clk), .i_rstn(rst_n), .i_gray(gray), .i_resync(resync), .i_clr(clr),
        .i_err_clr(err_clr), .o_bin(bin_a), .o_delta(delta_a), .o_delta_vld(vld_a),
        .o_acc(acc_a), .o_acc_ovf(ovf_a), .o_err(err_a), .o_primed(primed_a)
    );

    counter_gray_rx_delta #(.BUS_WIDTH(W), .ACC_WIDTH(4)) dut_b (
        .i_clk(clk), .i_rstn(rst_n), .i_gray(gray), .i_resync(resync), .i_clr(clr),
        .i_err_clr(err_clr), .o_bin(bin_b), .o_delta(delta_b), .o_delta_vld(vld_b),
        .o_acc(acc_b), .o_acc_ovf(ovf_b), .o_err(err_b), .o_primed(primed_b)
    );

    // Behavioural reference: phase counts edges since reset/resync (0 waiting, 1 priming, 2 running).
    int m_phase, m_gq, m_ref_bin, m_ref_gray, m_bin, m_delta, m_vld, m_err, m_primed;
    int m_acc16, m_ovf16, m_acc4, m_ovf4;
    int cur_bin;

    function automatic int g2b(input int g);
        int b = 0;
        for (int i = 0; i < W; i++) b = b ^ (g >> i);
        return b & 15;
    endfunction

    function automatic int b2g(input int b);
        return (b ^ (b >> 1)) & 15;
    endfunction

    task automatic model_reset();
        m_phase = 0; m_gq = 0; m_ref_bin = 0; m_ref_gray = 0; m_bin = 0; m_delta = 0;
        m_vld = 0; m_err = 0; m_primed = 0; m_acc16 = 0; m_ovf16 = 0; m_acc4 = 0; m_ovf4 = 0;
    endtask

    task automatic model_edge(input int g, input int rs, input int cl, input int ec);
        int now_bin, d, h, legal, bad;
        now_bin = g2b(m_gq);
        d       = (now_bin - m_ref_bin + 16) % 16;
        h       = $countones(m_gq ^ m_ref_gray);
        legal   = (m_phase == 2 && !rs && h == 1);
        bad     = (m_phase == 2 && !rs && h > 1);
        if (cl) begin m_acc16 = 0; m_ovf16 = 0; m_acc4 = 0; m_ovf4 = 0; end
        if (legal) begin
            m_acc16 = m_acc16 + d;
            if (m_acc16 > 65535) begin m_acc16 = 65535; m_ovf16 = 1; end
            m_acc4 = m_acc4 + d;
            if (m_acc4 > 15) begin m_acc4 = 15; m_ovf4 = 1; end
        end
        if (ec) m_err = 0;
        if (bad) m_err = 1;
        m_delta = legal ? d : 0;
        m_vld   = legal;
        if (m_phase == 1 || (m_phase == 2 && !rs)) begin
            m_ref_gray = m_gq; m_ref_bin = now_bin; m_bin = now_bin;
        end
        if (rs || m_phase == 0) m_phase = 1;
        else m_phase = 2;
        m_primed = (m_phase == 2);
        m_gq = g;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("bin",    32'(bin_a),    32'(m_bin));
        chk("delta",  32'(delta_a),  32'(m_delta));
        chk("vld",    32'(vld_a),    32'(m_vld));
        chk("acc16",  32'(acc_a),    32'(m_acc16));
        chk("ovf16",  32'(ovf_a),    32'(m_ovf16));
        chk("err",    32'(err_a),    32'(m_err));
        chk("primed", 32'(primed_a), 32'(m_primed));
        chk("acc4",   32'(acc_b),    32'(m_acc4));
        chk("ovf4",   32'(ovf_b),    32'(m_ovf4));
        chk("bin4",   32'(bin_b),    32'(m_bin));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_bin"},    32'(bin_a),    0);
        chk({tag, "_delta"},  32'(delta_a),  0);
        chk({tag, "_vld"},    32'(vld_a),    0);
        chk({tag, "_acc"},    32'(acc_a),    0);
        chk({tag, "_ovf"},    32'(ovf_a),    0);
        chk({tag, "_err"},    32'(err_a),    0);
        chk({tag, "_primed"}, 32'(primed_a), 0);
        chk({tag, "_acc4"},   32'(acc_b),    0);
    endtask

    task automatic step(input int g, input int rs, input int cl, input int ec);
        gray = 4'(g); resync = rs[0]; clr = cl[0]; err_clr = ec[0];
        @(posedge clk);
        model_edge(g, rs, cl, ec);
        #1;
        check_all();
    endtask

    initial begin
        model_reset();
        // Reset with Gray held at zero
        repeat (3) begin @(posedge clk); #1; check_zero("rst"); end
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("t1_primed", 32'(primed_a), 1);

        // Count 0..4 in Gray
        step(1, 0, 0, 0); step(3, 0, 0, 0); step(2, 0, 0, 0); step(6, 0, 0, 0); step(6, 0, 0, 0);
        chk("t2_bin", 32'(bin_a), 4);
        chk("t2_acc", 32'(acc_a), 4);

        // Re-prime at bin 14, then wrap 15 -> 0
        step(9, 1, 1, 0); step(9, 0, 0, 0); step(9, 0, 0, 0);
        step(8, 0, 0, 0); step(0, 0, 0, 0);
        chk("t3_bin15", 32'(bin_a), 15);
        step(0, 0, 0, 0);
        chk("t3_bin0", 32'(bin_a), 0);
        chk("t3_delta", 32'(delta_a), 1);
        chk("t3_acc", 32'(acc_a), 2);
        chk("t3_err", 32'(err_a), 0);

        // Illegal two-bit jump, then legal step, then error clear
        step(3, 0, 0, 0); step(3, 0, 0, 0);
        chk("t4_err", 32'(err_a), 1);
        chk("t4_vld", 32'(vld_a), 0);
        chk("t4_bin", 32'(bin_a), 2);
        step(2, 0, 0, 0); step(2, 0, 0, 0);
        chk("t4_vld_legal", 32'(vld_a), 1);
        chk("t4_err_sticky", 32'(err_a), 1);
        step(2, 0, 0, 1);
        chk("t4_err_clr", 32'(err_a), 0);

        // Saturate the 4-bit accumulator
        cur_bin = 3;
        step(b2g(cur_bin), 0, 1, 0);
        for (int i = 0; i < 16; i++) begin
            cur_bin = (cur_bin + 1) % 16;
            step(b2g(cur_bin), 0, 0, 0);
        end
        step(b2g(cur_bin), 0, 0, 0);
        chk("t5_acc4_sat", 32'(acc_b), 15);
        chk("t5_ovf4", 32'(ovf_b), 1);
        cur_bin = (cur_bin + 1) % 16;
        step(b2g(cur_bin), 0, 0, 0);
        step(b2g(cur_bin), 0, 1, 0);
        chk("t5_acc4_clr", 32'(acc_b), 1);
        chk("t5_ovf4_clr", 32'(ovf_b), 0);

        // Asynchronous reset mid-cycle
        for (int i = 0; i < 6; i++) begin
            cur_bin = (cur_bin + 1) % 16;
            step(b2g(cur_bin), 0, 0, 0);
        end
        #3 rst_n = 1'b0;
        #1 check_zero("arst");
        model_reset();
        rst_n = 1'b1;
        step(b2g(cur_bin), 0, 0, 0);
        chk("t6_primed0", 32'(primed_a), 0);
        step(b2g(cur_bin), 0, 0, 0); step(b2g(cur_bin), 0, 0, 0);

        // Random Gray walk with occasional skew, resync, clear and error clear
        for (int i = 0; i < 400; i++) begin
            int r, rs, cl, ec;
            r = $urandom_range(0, 99);
            if (r < 45) cur_bin = (cur_bin + 1) % 16;
            else if (r < 75) cur_bin = (cur_bin + 15) % 16;
            else if (r < 90) cur_bin = cur_bin;
            else cur_bin = $urandom_range(0, 15);
            rs = ($urandom_range(0, 99) < 4) ? 1 : 0;
            cl = ($urandom_range(0, 99) < 5) ? 1 : 0;
            ec = ($urandom_range(0, 99) < 6) ? 1 : 0;
            step(b2g(cur_bin), rs, cl, ec);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
